dark_channel_window_ctrl: RTL and testbench
===========================================

// Module: dark_channel_window_ctrl
// PURPOSE
//  Streaming controller that sequences the 3x3 dark-channel datapath.
//  - Accepts raster-order RGB pixels and buffers two image lines.
//  - Presents each interior 3x3 window plus its centre-pixel edge flag on a registered valid/ready output.
//  - Frames start on a start pulse; frame completion is reported.
//  - Sits between the pixel source / edge detector and the dark-channel min block.
// PARAMETERS
//  IMG_W  64  pixels per line (>=3)
//  IMG_H  48  lines per frame (>=3)
//  PIX_W  24  pixel width; [7:0]=R, [15:8]=G, [23:16]=B
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        one-cycle frame start; sampled only in IDLE
//  pix_valid   in   1        input pixel valid
//  pix_ready   out  1        input pixel accepted when pix_valid & pix_ready
//  pix_data    in   PIX_W    input pixel
//  pix_ed      in   1        edge flag for pix_data
//  win_valid   out  1        window outputs valid
//  win_ready   in   1        downstream accepts window
//  win_flat    out  9*PIX_W  {i,h,g,f,e,d,c,b,a}; a = bits [PIX_W-1:0]
//  win_ed      out  1        edge flag of centre pixel e (drives ED_in)
//  busy        out  1        high in RUN and DRAIN
//  frame_done  out  1        one-cycle pulse at end of frame
//  dc_min_all  in   8        datapath min over R,G,B (used only with ATM_LIGHT_EN)
//  dc_valid    in   1        dc_min_all valid (used only with ATM_LIGHT_EN)
//  atm_light   out  8        frame maximum of dc_min_all
//  atm_valid   out  1        atm_light final for the last frame
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; col/row counters 0.
//   Line RAM contents are not cleared.
//  FSM states:
//   IDLE  -> RUN on start. pix_ready=0.
//   RUN   -> DRAIN when pixel (IMG_H-1, IMG_W-1) is accepted.
//   DRAIN -> DONE when the output register is empty (no pending window).
//   DONE  -> IDLE after 1 cycle. frame_done=1 only in DONE.
//   start is ignored outside IDLE.
//  Counters:
//   col increments per accepted pixel; it wraps IMG_W-1 -> 0 and row increments on the wrap.
//   Both counters clear on start.
//  Line buffers: two IMG_W x (PIX_W+1) delay lines (pixel + ed flag), written on accept only.
//   Also hold the last two accepted pixels of the current and previous two lines.
//  Window formation: on accepting pixel (r,c) with r>=2 and c>=2, load the output register with:
//   a,b,c = line r-2, cols c-2..c
//   d,e,f = line r-1, cols c-2..c
//   g,h,i = line r,   cols c-2..c (i = the accepted pixel)
//   win_ed = ed of (r-1,c-1).
//   No window for r<2 or c<2. Windows per frame = (IMG_W-2)*(IMG_H-2).
//  Latency: win_valid rises the cycle after the accepting edge.
//  Handshake:
//   pix_ready = (state==RUN) & (~win_valid | win_ready).
//   win_valid holds with win_flat/win_ed stable until win_ready.
//   Simultaneous window consume + new load: the new window replaces the old, with no bubble.
//  Pixels presented outside RUN are not accepted.
//  Reset mid-frame: return to IDLE immediately and drop the pending window; the next frame refills the lines.
// CONFIGURATION
//  ATM_LIGHT_EN defined:
//   atm_light clears to 0 on start.
//   In RUN/DRAIN, each cycle with dc_valid: atm_light <= max(atm_light, dc_min_all).
//   atm_valid clears on start, sets in DONE, and holds until the next start.
//  ATM_LIGHT_EN undefined:
//   atm_light=0 and atm_valid=0 constantly; dc_min_all/dc_valid are ignored.
// TESTING (IMG_W=4, IMG_H=4; pixel n has R=G=B=n, n=0..15)
//  1. Reset: drive rst_n=0 mid-RUN -> next cycle all outputs 0, state IDLE.
//     After a new start the full frame yields exactly 4 windows.
//  2. Window contents: stream n=0..15 with win_ready=1.
//     - After n=10: a..i = 0,1,2,4,5,6,8,9,10.
//     - Then windows with i=11, 14, 15.
//     - Accepting n=12/13 produces no window.
//  3. Backpressure: hold win_ready=0 for 5 cycles with window i=10 pending.
//     -> pix_ready=0, win_flat stable, no pixel lost. Release -> window i=11 follows.
//  4. Edge flag: pix_ed=1 only for n=5 -> win_ed=1 on the first window only.
//     pix_ed=1 only for n=10 -> win_ed=1 on the last window (centre 10).
//  5. End of frame: last window handshake -> frame_done pulses exactly once, then IDLE.
//     A start asserted during RUN is ignored (window count unchanged).
//  6. ATM_LIGHT_EN: dc_min_all = 10, 200, 37 with dc_valid -> atm_light=200, atm_valid=1 at DONE.
//     Without the macro -> atm_light=0, atm_valid=0.

Source files
------------

// File: rtl/dark_channel_window_ctrl.sv
// dark_channel_window_ctrl: line-buffered 3x3 window sequencer; optional ATM_LIGHT_EN frame max tracker
module dark_channel_window_ctrl #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 48,
   parameter int PIX_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [PIX_W-1:0]   pix_data,
   input  logic               pix_ed,
   output logic               win_valid,
   input  logic               win_ready,
   output logic [9*PIX_W-1:0] win_flat,
   output logic               win_ed,
   output logic               busy,
   output logic               frame_done,
   input  logic [7:0]         dc_min_all,
   input  logic               dc_valid,
   output logic [7:0]         atm_light,
   output logic               atm_valid
);
   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int EW = PIX_W + 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
   logic [1:0] state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [EW-1:0] l1_q [IMG_W];
   logic [PIX_W-1:0] l2_q [IMG_W];
   logic [PIX_W-1:0] top_c1_q, top_c2_q, mid_c2_q, bot_c1_q, bot_c2_q;
   logic [EW-1:0] mid_c1_q;
   logic [9*PIX_W-1:0] win_q, win_d;
   logic win_valid_q, win_valid_d, win_ed_q, win_ed_d;
   logic accept, last_col, last_pix, load, go;
   logic [EW-1:0] cur, mid;
   logic [PIX_W-1:0] top;
   assign cur = {pix_ed, pix_data};
   assign mid = l1_q[IMG_W-1];
   assign top = l2_q[IMG_W-1];
   assign go = (state_q == S_IDLE) && start;
   assign pix_ready = (state_q == S_RUN) && (!win_valid_q || win_ready);
   assign accept = pix_valid && pix_ready;
   assign last_col = col_q == CW'(IMG_W - 1);
   assign last_pix = last_col && (row_q == RW'(IMG_H - 1));
   assign load = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
   // frame sequencing: idle -> run -> drain pending window -> one-cycle done
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = start ? S_RUN : S_IDLE;
         S_RUN:   state_d = (accept && last_pix) ? S_DRAIN : S_RUN;
         S_DRAIN: state_d = win_valid_q ? S_DRAIN : S_DONE;
         default: state_d = S_IDLE;
      endcase
   end
   // raster position of the next pixel to be accepted
   always_comb begin
      col_d = go ? '0 : accept ? (last_col ? '0 : col_q + 1'b1) : col_q;
      row_d = go ? '0 : (accept && last_col) ? row_q + 1'b1 : row_q;
   end
   // output register: a new window replaces a consumed one without a bubble
   always_comb begin
      win_valid_d = load || (win_valid_q && !win_ready);
      win_d = load ? {cur[PIX_W-1:0], bot_c1_q, bot_c2_q, mid[PIX_W-1:0], mid_c1_q[PIX_W-1:0], mid_c2_q,
                      top, top_c1_q, top_c2_q} : win_q;
      win_ed_d = load ? mid_c1_q[PIX_W] : win_ed_q;
   end
   // control state and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         col_q <= '0;
         row_q <= '0;
         win_q <= '0;
         win_valid_q <= 1'b0;
         win_ed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q <= col_d;
         row_q <= row_d;
         win_q <= win_d;
         win_valid_q <= win_valid_d;
         win_ed_q <= win_ed_d;
      end
   end
   // line delay lines give (r-1,c) and (r-2,c); column regs keep the two previous columns
   always_ff @(posedge clk) begin
      if (accept) begin
         l1_q[0] <= cur;
         l2_q[0] <= mid[PIX_W-1:0];
         for (int k = 1; k < IMG_W; k++) begin
            l1_q[k] <= l1_q[k-1];
            l2_q[k] <= l2_q[k-1];
         end
         top_c1_q <= top;
         top_c2_q <= top_c1_q;
         mid_c1_q <= mid;
         mid_c2_q <= mid_c1_q[PIX_W-1:0];
         bot_c1_q <= cur[PIX_W-1:0];
         bot_c2_q <= bot_c1_q;
      end
   end
   assign win_valid = win_valid_q;
   assign win_flat = win_q;
   assign win_ed = win_ed_q;
   assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign frame_done = state_q == S_DONE;
`ifdef ATM_LIGHT_EN
   logic [7:0] atm_q;
   logic atm_valid_q;
   // running max of the datapath dark value, final once the frame reaches DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         atm_q <= '0;
         atm_valid_q <= 1'b0;
      end else if (go) begin
         atm_q <= '0;
         atm_valid_q <= 1'b0;
      end else begin
         if (busy && dc_valid && (dc_min_all > atm_q)) atm_q <= dc_min_all;
         if (state_q == S_DRAIN && !win_valid_q) atm_valid_q <= 1'b1;
      end
   end
   assign atm_light = atm_q;
   assign atm_valid = atm_valid_q;
`else
   logic unused_dc;
   assign unused_dc = ^{dc_min_all, dc_valid};
   assign atm_light = '0;
   assign atm_valid = 1'b0;
`endif
endmodule

// File: tb/tb_dark_channel_window_ctrl.sv
// tb_dark_channel_window_ctrl: directed bench for the 3x3 window controller on a 4x4 frame
module tb_dark_channel_window_ctrl;
   typedef logic [215:0] val_t;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0, pix_ed = 1'b0, win_ready = 1'b1, dc_valid = 1'b0;
   logic [23:0] pix_data = '0;
   logic [7:0] dc_min_all = '0;
   logic pix_ready, win_valid, win_ed, busy, frame_done, atm_valid;
   logic [215:0] win_flat;
   logic [7:0] atm_light;
   int checks = 0, failures = 0, done_cnt = 0;
   logic [215:0] wq [$];
   logic eq [$];

   dark_channel_window_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_ed(pix_ed), .win_valid(win_valid), .win_ready(win_ready),
      .win_flat(win_flat), .win_ed(win_ed), .busy(busy), .frame_done(frame_done),
      .dc_min_all(dc_min_all), .dc_valid(dc_valid), .atm_light(atm_light), .atm_valid(atm_valid)
   );

   always #5 clk = ~clk;

   // record every window handshake and every done pulse mid-cycle
   always @(negedge clk) begin
      if (win_valid && win_ready) begin
         wq.push_back(win_flat);
         eq.push_back(win_ed);
      end
      if (frame_done) done_cnt++;
   end

   task automatic check(input string tag, input val_t got, input val_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic val_t exp_win(int r, int c);
      val_t w = '0;
      logic [7:0] n;
      for (int k = 0; k < 9; k++) begin
         n = 8'((r - 2 + k / 3) * 4 + c - 2 + k % 3);
         w[k*24 +: 24] = {n, n, n};
      end
      return w;
   endfunction

   task automatic send(input int n, input logic ed);
      int k = 0;
      pix_data = {3{8'(n)}};
      pix_ed = ed;
      pix_valid = 1'b1;
      #1;
      while (!pix_ready && k < 50) begin
         step();
         k++;
      end
      if (k == 50) check("pix_timeout", val_t'(pix_ready), val_t'(1'b1));
      step();
      pix_valid = 1'b0;
      pix_ed = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_win_valid"}, val_t'(win_valid), '0);
      check({tag, "_win_flat"}, win_flat, '0);
      check({tag, "_win_ed"}, val_t'(win_ed), '0);
      check({tag, "_busy"}, val_t'(busy), '0);
      check({tag, "_pix_ready"}, val_t'(pix_ready), '0);
      check({tag, "_frame_done"}, val_t'(frame_done), '0);
      check({tag, "_atm_light"}, val_t'(atm_light), '0);
      check({tag, "_atm_valid"}, val_t'(atm_valid), '0);
   endtask

   task automatic run_frame(input int ed_n, input logic stall, input logic mid_start);
      int k = 0, d0;
      logic [215:0] held;
      wq.delete();
      eq.delete();
      d0 = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_run", val_t'(busy), val_t'(1'b1));
      for (int n = 0; n < 16; n++) begin
         dc_valid = (n >= 3 && n <= 5);
         dc_min_all = (n == 3) ? 8'd10 : (n == 4) ? 8'd200 : 8'd37;
         start = mid_start && n == 7;
         send(n, n == ed_n);
         start = 1'b0;
         dc_valid = 1'b0;
         if (n == 10) begin
            check("lat_valid", val_t'(win_valid), val_t'(1'b1));
            check("win_first", win_flat, exp_win(2, 2));
            if (stall) begin
               held = win_flat;
               win_ready = 1'b0;
               pix_data = {3{8'd11}};
               pix_valid = 1'b1;
               for (int s = 0; s < 5; s++) begin
                  #1;
                  check("stall_ready", val_t'(pix_ready), '0);
                  check("stall_stable", win_flat, held);
                  step();
               end
               win_ready = 1'b1;
            end
         end
         if (n == 12 || n == 13) check("no_win", val_t'(win_valid), '0);
      end
      while (!frame_done && k < 30) begin
         step();
         k++;
      end
      check("done_seen", val_t'(frame_done), val_t'(1'b1));
      repeat (3) step();
      check("done_once", val_t'(done_cnt - d0), val_t'(1));
      check("idle_busy", val_t'(busy), '0);
      check("idle_ready", val_t'(pix_ready), '0);
      check("nwin", val_t'(wq.size()), val_t'(4));
      for (int j = 0; j < 4 && j < wq.size(); j++) begin
         check($sformatf("win%0d", j), wq[j], exp_win(2 + j / 2, 2 + j % 2));
         check($sformatf("ed%0d", j), val_t'(eq[j]), val_t'((ed_n == 5 && j == 0) || (ed_n == 10 && j == 3)));
      end
`ifdef ATM_LIGHT_EN
      check("atm_light", val_t'(atm_light), val_t'(8'd200));
      check("atm_valid", val_t'(atm_valid), val_t'(1'b1));
`else
      check("atm_light", val_t'(atm_light), '0);
      check("atm_valid", val_t'(atm_valid), '0);
`endif
   endtask

   initial begin
      repeat (2) step();
      check_idle("rst");
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 0; n < 11; n++) send(n, 1'b0);
      win_ready = 1'b0;
      #1;
      check("pre_rst_valid", val_t'(win_valid), val_t'(1'b1));
      rst_n = 1'b0;
      #1;
      check_idle("midrst");
      step();
      rst_n = 1'b1;
      win_ready = 1'b1;
      step();
      run_frame(5, 1'b0, 1'b0);
      run_frame(10, 1'b1, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
